// File: rtl/gpr_wb_sched_pkg.sv
// ---------------------------------------------------------------------------
// gpr_wb_sched_pkg
// Shared widths, types and grant encoding for the GPR write-port scheduler.
// No ports (package).
// ---------------------------------------------------------------------------
package gpr_wb_sched_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    // Bit positions in the arbiter request/grant vectors
    localparam int unsigned GNT_ALU = 0;
    localparam int unsigned GNT_LSU = 1;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/gpr_wb_sched_if.sv
// ---------------------------------------------------------------------------
// gpr_wb_sched_if
// Bundles the issue, ALU writeback, LSU writeback and GPR write-port signals
// of the scheduler.
//   slave  : seen by gpr_wb_sched (takes iss_*/alu_wb_*/lsu_wb_*, drives
//            iss_stall, *_ready, gpr_*, busy)
//   master : seen by the surrounding pipeline / testbench
// ---------------------------------------------------------------------------
interface gpr_wb_sched_if;
    import gpr_wb_sched_pkg::*;

    // Issue stage
    logic      iss_valid;
    reg_addr_t iss_rs1;
    reg_addr_t iss_rs2;
    reg_addr_t iss_rd;
    logic      iss_rd_wr;
    logic      iss_is_load;
    logic      iss_stall;

    // ALU/CSR/PC writeback
    logic      alu_wb_valid;
    reg_addr_t alu_wb_rd;
    xlen_t     alu_wb_data;
    logic      alu_wb_ready;

    // LSU load response
    logic      lsu_wb_valid;
    reg_addr_t lsu_wb_rd;
    xlen_t     lsu_wb_data;
    logic      lsu_wb_ready;

    // GPR write port and status
    logic      gpr_we;
    reg_addr_t gpr_waddr;
    xlen_t     gpr_wdata;
    logic      busy;

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wr, iss_is_load,
        output iss_stall,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        output alu_wb_ready,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output lsu_wb_ready,
        output gpr_we, gpr_waddr, gpr_wdata, busy
    );

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wr, iss_is_load,
        input  iss_stall,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  alu_wb_ready,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  lsu_wb_ready,
        input  gpr_we, gpr_waddr, gpr_wdata, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester is granted directly; on a
// conflict the requester that lost the previous conflict wins. The
// last-grant register only moves on conflict cycles.
//   clk    in  1  clock, rising edge
//   rstn   in  1  asynchronous active-low reset (last grant = ALU)
//   i_req  in  2  request vector, [GNT_ALU] / [GNT_LSU]
//   o_gnt  out 2  one-hot (or zero) grant vector, same bit order
// ---------------------------------------------------------------------------
module rr_arb2
    import gpr_wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last_lsu;   // 1: LSU won the last conflict
    logic w_conflict;

    assign w_conflict = &i_req;

    always_comb begin
        o_gnt = i_req;
        if (w_conflict) begin
            o_gnt = '0;
            if (r_last_lsu) begin
                o_gnt[GNT_ALU] = 1'b1;
            end else begin
                o_gnt[GNT_LSU] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_lsu <= 1'b0;
        end else if (w_conflict) begin
            r_last_lsu <= ~r_last_lsu;
        end
    end

endmodule

// File: rtl/gpr_wb_sched.sv
// ---------------------------------------------------------------------------
// gpr_wb_sched
// GPR write-port scheduler and load scoreboard. Arbitrates the single GPR
// write port between ALU writeback and LSU load responses, registers the
// winning write, and stalls issue on RAW/WAW hazards against outstanding
// loads or when the outstanding-load budget is full.
//   clk   in  1       clock, rising edge
//   rstn  in  1       asynchronous active-low reset
//   bus   slave       iss_*, alu_wb_*, lsu_wb_*, gpr_*, busy (see interface)
// Parameters:
//   MAX_LOADS  outstanding-load budget (1..15)
//   CNT_W      counter width, 2**CNT_W > MAX_LOADS
// ---------------------------------------------------------------------------
module gpr_wb_sched
    import gpr_wb_sched_pkg::*;
#(
    parameter int unsigned MAX_LOADS = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic           clk,
    input  logic           rstn,
    gpr_wb_sched_if.slave  bus
);

    if (MAX_LOADS < 1 || MAX_LOADS > 15 || (1 << CNT_W) <= MAX_LOADS) begin : g_bad_param
        $error("gpr_wb_sched: illegal MAX_LOADS/CNT_W combination");
    end

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_stall;
    logic                w_cnt_full;
    logic                w_set;
    logic                w_cnt_dec;
    logic                w_acc_any;
    reg_addr_t           w_acc_rd;
    xlen_t               w_acc_data;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_we;
    reg_addr_t           r_waddr;
    xlen_t               r_wdata;
    logic                r_from_lsu;   // registered write slot holds an LSU response

    // ---------------- write-port arbitration ----------------
    assign w_req[GNT_ALU] = bus.alu_wb_valid;
    assign w_req[GNT_LSU] = bus.lsu_wb_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign bus.alu_wb_ready = w_gnt[GNT_ALU];
    assign bus.lsu_wb_ready = w_gnt[GNT_LSU];

    assign w_acc_any  = |w_gnt;
    assign w_acc_rd   = w_gnt[GNT_LSU] ? bus.lsu_wb_rd   : bus.alu_wb_rd;
    assign w_acc_data = w_gnt[GNT_LSU] ? bus.lsu_wb_data : bus.alu_wb_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_from_lsu <= 1'b0;
        end else if (w_acc_any) begin
            // x0 writes complete the handshake but never reach the GPR
            r_we       <= (w_acc_rd != '0);
            r_waddr    <= w_acc_rd;
            r_wdata    <= w_acc_data;
            r_from_lsu <= w_gnt[GNT_LSU];
        end else begin
            r_we       <= 1'b0;
            r_from_lsu <= 1'b0;
        end
    end

    assign bus.gpr_we    = r_we;
    assign bus.gpr_waddr = r_waddr;
    assign bus.gpr_wdata = r_wdata;

    // ---------------- issue hazard check ----------------
    assign w_cnt_full = (r_cnt == CNT_W'(MAX_LOADS));

    // Registered pending only: a load clearing this edge is seen next cycle
    always_comb begin
        w_stall = 1'b0;
        if (bus.iss_valid) begin
            if (bus.iss_rs1 != '0 && r_pending[bus.iss_rs1]) begin
                w_stall = 1'b1;
            end
            if (bus.iss_rs2 != '0 && r_pending[bus.iss_rs2]) begin
                w_stall = 1'b1;
            end
            if (bus.iss_rd_wr && bus.iss_rd != '0 && r_pending[bus.iss_rd]) begin
                w_stall = 1'b1;
            end
            if (bus.iss_is_load && w_cnt_full) begin
                w_stall = 1'b1;
            end
        end
    end

    assign bus.iss_stall = w_stall;

    // ---------------- scoreboard and load counter ----------------
    assign w_set = bus.iss_valid & ~w_stall & bus.iss_is_load & bus.iss_rd_wr &
                   (bus.iss_rd != '0);
    // Responses with nothing outstanding are dropped without underflow
    assign w_cnt_dec = r_from_lsu & (r_cnt != '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_set, w_cnt_dec})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_comb begin
        w_pending_nxt = r_pending;
        if (r_from_lsu) begin
            w_pending_nxt[r_waddr] = 1'b0;
        end
        if (w_set) begin
            w_pending_nxt[bus.iss_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= (w_cnt_nxt != '0);
        end
    end

    assign bus.busy = r_busy;

endmodule
